// File: rtl/counter_pkg.sv
// Shared widths and entry packing for the counter capture path.
package counter_pkg;
   localparam int CNT_W   = 36;
   localparam int ENTRY_W = CNT_W + 1;

   function automatic logic [ENTRY_W-1:0] entry_pack(input logic wrap, input logic [CNT_W-1:0] cnt);
      return {wrap, cnt};
   endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// Show-ahead synchronous FIFO with a registered occupancy counter.
module sync_fifo_fwft #(
   parameter int W     = 37,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level
);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   level_q, level_d;
   logic          pop_ok, push_ok;

   assign empty   = (level_q == '0);
   assign full    = (level_q == (AW+1)'(DEPTH));
   assign pop_ok  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
   assign push_ok = push & (~full | pop_ok);
   assign level_d = level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
   assign level   = level_q;
   assign dout    = empty ? '0 : mem_q[rd_q];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         if (push_ok) wr_q <= wr_q + 1'b1;
         if (pop_ok)  rd_q <= rd_q + 1'b1;
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= din;
   end
endmodule

// File: rtl/counter_capture_fifo.sv
// Snapshots the live cluster count into a FIFO on capture, tagging rollovers since the last snapshot.
module counter_capture_fifo
   import counter_pkg::*;
#(
   parameter int N     = CNT_W,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  count_in,
   input  logic          capture,
   output logic [N:0]    out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level,
   output logic          overflow,
   input  logic          clear_ovf
);
   logic [N-1:0] prev_q;
   logic         wrap_pend_q, wrap_pend_d;
   logic         overflow_q, overflow_d;
   logic         wrap_now, pop, push_ok;

   assign wrap_now  = (count_in < prev_q);
   assign out_valid = ~empty;
   assign pop       = out_valid & out_ready;
   assign push_ok   = capture & (~full | pop);
   assign overflow  = overflow_q;

   always_comb begin
      wrap_pend_d = push_ok ? 1'b0 : (wrap_pend_q | wrap_now);
      overflow_d  = overflow_q;
      // A drop outranks a concurrent clear so no lost capture goes unreported.
      if (capture & ~push_ok) overflow_d = 1'b1;
      else if (clear_ovf)     overflow_d = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_q      <= '0;
         wrap_pend_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         prev_q      <= count_in;
         wrap_pend_q <= wrap_pend_d;
         overflow_q  <= overflow_d;
      end
   end

   sync_fifo_fwft #(.W(N+1), .DEPTH(DEPTH), .AW(AW)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_ok),
      .pop   (pop),
      .din   (entry_pack(wrap_pend_q | wrap_now, count_in)),
      .dout  (out_data),
      .full  (full),
      .empty (empty),
      .level (level)
   );
endmodule

// File: tb/tb_counter_capture_fifo.sv
// Directed and random checks of counter_capture_fifo against a queue-based reference model.
module tb_counter_capture_fifo;
   localparam int N = 36;
   localparam int DEPTH = 4;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [N-1:0]  count_in = '0;
   logic          capture = 1'b0;
   logic [N:0]    out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          full, empty;
   logic [AW:0]   level;
   logic          overflow;
   logic          clear_ovf = 1'b0;

   int tests = 0;
   int fails = 0;

   logic [N:0]   mq[$];
   logic [N-1:0] m_prev = '0;
   bit           m_wp = 0;
   bit           m_ovf = 0;

   counter_capture_fifo #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .reset(reset), .count_in(count_in), .capture(capture),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .full(full), .empty(empty), .level(level), .overflow(overflow),
      .clear_ovf(clear_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [N:0] head;
      head = (mq.size() > 0) ? mq[0] : '0;
      chk({tag, ".level"},    64'(level),     64'(mq.size()));
      chk({tag, ".empty"},    64'(empty),     64'(mq.size() == 0));
      chk({tag, ".full"},     64'(full),      64'(mq.size() == DEPTH));
      chk({tag, ".valid"},    64'(out_valid), 64'(mq.size() != 0));
      chk({tag, ".overflow"}, 64'(overflow),  64'(m_ovf));
      chk({tag, ".data"},     64'(out_data),  64'(head));
   endtask

   // Drive one cycle's inputs, advance the model by the capture/pop rules, and compare after the edge.
   task automatic step(input bit cap, input bit rdy, input logic [N-1:0] cnt, input bit clr, input string tag);
      bit pop, push, wn;
      capture = cap; out_ready = rdy; count_in = cnt; clear_ovf = clr;
      pop  = (mq.size() > 0) && rdy;
      wn   = cnt < m_prev;
      push = cap && ((mq.size() < DEPTH) || pop);
      @(posedge clk);
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back({m_wp | wn, cnt});
      if (cap && !push) m_ovf = 1;
      else if (clr) m_ovf = 0;
      m_wp = push ? 1'b0 : (m_wp | wn);
      m_prev = cnt;
      #1;
      check_model(tag);
   endtask

   task automatic model_reset();
      mq.delete();
      m_prev = '0;
      m_wp = 0;
      m_ovf = 0;
   endtask

   initial begin
      model_reset();
      #1;
      chk("rst.level", 64'(level), 64'd0);
      chk("rst.empty", 64'(empty), 64'd1);
      chk("rst.valid", 64'(out_valid), 64'd0);
      chk("rst.data",  64'(out_data), 64'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Reset mid-stream with three entries held.
      for (int i = 0; i < 3; i++) step(1, 0, 36'(i + 7), 0, "fill3");
      chk("pre_rst.level", 64'(level), 64'd3);
      #2 reset = 1'b1;
      #1;
      model_reset();
      chk("async_rst.level", 64'(level), 64'd0);
      chk("async_rst.empty", 64'(empty), 64'd1);
      chk("async_rst.valid", 64'(out_valid), 64'd0);
      chk("async_rst.ovf",   64'(overflow), 64'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      check_model("post_rst");

      // Basic capture and pop.
      step(1, 0, 36'h0_0000_0010, 0, "basic.cap");
      chk("basic.data", 64'(out_data), 64'h0_0000_0010);
      chk("basic.level", 64'(level), 64'd1);
      step(0, 1, 36'h0_0000_0011, 0, "basic.pop");
      chk("basic.empty", 64'(empty), 64'd1);

      // Rollover tagging.
      step(0, 0, 36'hF_FFFF_FFFF, 0, "wrap.hi");
      step(0, 0, 36'h0_0000_0002, 0, "wrap.lo");
      step(0, 0, 36'h0_0000_0002, 0, "wrap.eq");
      step(1, 0, 36'h0_0000_0003, 0, "wrap.cap");
      chk("wrap.msb", 64'(out_data[N]), 64'd1);
      step(0, 1, 36'h0_0000_0004, 0, "wrap.pop");
      step(1, 0, 36'h0_0000_0005, 0, "nowrap.cap");
      chk("nowrap.msb", 64'(out_data[N]), 64'd0);
      step(0, 1, 36'h0_0000_0006, 0, "nowrap.pop");

      // Fill past capacity, then drain in order.
      for (int i = 0; i < 5; i++) step(1, 0, 36'(100 + i), 0, "ovf.fill");
      chk("ovf.level", 64'(level), 64'd4);
      chk("ovf.full",  64'(full), 64'd1);
      chk("ovf.flag",  64'(overflow), 64'd1);
      for (int i = 0; i < 4; i++) begin
         chk("ovf.order", 64'(out_data), 64'(100 + i));
         step(0, 1, 36'(200), 0, "ovf.drain");
      end
      chk("ovf.drained", 64'(empty), 64'd1);

      // Push and pop together while full.
      step(0, 0, 36'(300), 1, "sim.clr");
      for (int i = 0; i < 4; i++) step(1, 0, 36'(301 + i), 0, "sim.fill");
      step(1, 1, 36'(310), 0, "sim.both");
      chk("sim.level", 64'(level), 64'd4);
      chk("sim.head",  64'(out_data), 64'(302));
      chk("sim.ovf",   64'(overflow), 64'd0);

      // Drop and clear in the same cycle.
      step(1, 0, 36'(311), 1, "clr.drop");
      chk("clr.set_wins", 64'(overflow), 64'd1);
      step(0, 0, 36'(312), 1, "clr.alone");
      chk("clr.cleared", 64'(overflow), 64'd0);

      // Random traffic, biased toward small steps with occasional rollovers.
      for (int i = 0; i < 400; i++) begin
         logic [N-1:0] c;
         c = ($urandom_range(0, 7) == 0) ? 36'($urandom_range(0, 15))
                                         : m_prev + 36'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) c = 36'hF_FFFF_FFF0 + 36'($urandom_range(0, 15));
         step($urandom_range(0, 1), $urandom_range(0, 2) == 0, c, $urandom_range(0, 7) == 0, "rnd");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
